la_event_counter: RTL
=====================

Name: la_event_counter

Overview:
- User-project-area block driven from the management SoC's logic analyzer (LA) bus.
- Firmware loads a value, sets a compare target and run/mode controls through LA bits, then starts it.
- The block runs a prescaled 32-bit counter with a match FSM.
- Count and status return on la_data_out. The low count half drives the user GPIO field mapped to mprj_io[31:16], which the chip-level bench watches as its check bits.

Parameters:
- COUNT_W, 32: counter and compare width. Fixed at 32 for the LA bit map below.
- PRESCALE, 4: clock cycles per count tick in RUN. Legal range 1..255.

Ports:
- wb_clk_i  input  1  single clock
- wb_rst_i  input  1  reset, synchronous, active-high
- la_data_in  input  128  LA data from management SoC
- la_oenb  input  128  LA output-enable, active-low: bit=0 means the SoC drives that bit
- la_data_out  output  128  LA data to management SoC
- io_out  output  16  user GPIO out, top maps to mprj_io[31:16]
- io_oeb  output  16  GPIO output-enable, active-low
- irq  output  3  user interrupts (see Optional Feature)

Behaviour:
- Clock and reset: one clock, wb_clk_i. Reset wb_rst_i is synchronous and active-high.
- Reset values:
  - count=0, state=IDLE, done=0, match_sticky=0, prescaler=0, compare=0.
  - la_data_out=0, io_out=0, io_oeb=16'hFFFF, irq=0.
  - io_oeb goes to 16'h0000 on the first clock after wb_rst_i deasserts.
- Qualified bit: q[i] = la_data_in[i] & ~la_oenb[i]. All control uses q.
- Load value is q[63:32].
- Compare register:
  - Per bit k in 0..31: compare[k] <= la_data_in[64+k] when la_oenb[64+k]==0, otherwise it holds.
- Control bits:
  - q[96] run, a level.
  - q[97] load, rising-edge detected.
  - q[98] clear, rising-edge detected.
  - q[99] mode: 0=free-running, 1=one-shot.
- Edge detection: previous q[98:97] is registered. Only a 0->1 transition acts. A bit held high acts once.
- Priority each cycle: clear > load > tick.
- Clear (any state):
  - count=0, done=0, match_sticky=0, prescaler=0.
  - state <= RUN if run, else IDLE.
- Load (any state):
  - count=q[63:32], done=0, prescaler=0.
  - match_sticky holds.
  - state <= RUN if run, else IDLE.
- FSM, encoding IDLE=2'd0, RUN=2'd1, DONE=2'd2:
  - IDLE: count holds, prescaler=0. run=1 -> RUN.
  - RUN:
    - prescaler increments each cycle. tick when prescaler==PRESCALE-1, then prescaler wraps to 0.
    - On tick, if count==compare:
      - mode=1: state -> DONE, count holds, done=1, match_sticky=1.
      - mode=0: count -> 0, match_sticky=1, one-cycle match pulse, stay RUN.
    - On tick with no match: count+1, wrapping 32'hFFFFFFFF -> 0 with no flag.
    - run=0 -> IDLE next cycle with count held. run=0 has priority over a same-cycle tick.
  - DONE: count and done hold. run=0 -> IDLE with done kept at 1. Only clear or load resets done.
- Latency: an LA change sampled at edge N shows on count/state/la_data_out at edge N+1. There is no combinational path from la_* to outputs.
- Outputs (registered):
  - la_data_out[31:0]=count
  - la_data_out[32]=done
  - la_data_out[33]=match_sticky
  - la_data_out[35:34]=state
  - la_data_out[127:36]=0
  - io_out=count[15:0]
- Reset mid-count returns everything to reset values on the next edge, regardless of LA inputs.

Optional Feature:
- Macro: LA_EVENT_IRQ_EN.
- Defined:
  - irq[0] is a one-cycle pulse on every match, either mode.
  - irq[1] is level done.
  - irq[2] is a one-cycle pulse on count wrap-around.
- Undefined: irq is tied to 3'b000 and no irq logic is synthesized. All other behaviour is identical.

Test Plan:
- Reset and output enable: hold wb_rst_i 3 cycles with random LA inputs -> la_data_out=0, io_out=0, io_oeb=16'hFFFF. io_oeb=0 one cycle after release.
- Load, run, one-shot:
  - Stimulus: load 32'h0000AB40, compare 32'h0000AB51, mode=1, run=1, PRESCALE=4.
  - io_out steps AB40 -> AB41 every 4 cycles.
  - Reaches AB51 after 17 ticks (68 cycles), then state=DONE, done=1, and count holds at AB51 for 100 further cycles.
- Free-running match:
  - Stimulus: compare=5, mode=0, clear then run.
  - Count sequence 0..5,0,1..., match_sticky=1 after the first wrap.
  - With the macro defined, irq[0] pulses every 6 ticks.
- Priority and edges:
  - Rise clear and load in the same cycle -> count=0.
  - Hold load high 10 cycles while running -> load applied exactly once, then counting resumes.
- oenb gating:
  - la_oenb[97]=1 with la_data_in[97] toggling -> no load.
  - Compare bits with la_oenb=1 keep their prior value.
- Wrap and abort:
  - Load 32'hFFFFFFFE, compare 0x10, run -> FFFFFFFF, 0, 1 with no done.
  - With the macro defined, irq[2] pulses on the wrap.
  - Assert wb_rst_i mid-run -> all reset values next edge.

Source files
------------

// File: rtl/la_event_counter.sv
// Prescaled 32-bit event counter with compare/match FSM, controlled over the LA bus.
// Optional irq outputs are built only when LA_EVENT_IRQ_EN is defined.
module la_event_counter #(
  parameter int unsigned COUNT_W  = 32,
  parameter int unsigned PRESCALE = 4
) (
  input  logic         wb_clk_i,
  input  logic         wb_rst_i,
  input  logic [127:0] la_data_in,
  input  logic [127:0] la_oenb,
  output logic [127:0] la_data_out,
  output logic [15:0]  io_out,
  output logic [15:0]  io_oeb,
  output logic [2:0]   irq
);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StRun  = 2'd1,
    StDone = 2'd2
  } state_e;

  localparam logic [7:0] PsLast = 8'(PRESCALE - 1);

  state_e               r_state, w_state_next;
  logic [COUNT_W-1:0]   r_count, w_count_next;
  logic [COUNT_W-1:0]   r_cmp, w_cmp_next;
  logic                 r_done, w_done_next;
  logic                 r_sticky, w_sticky_next;
  logic [7:0]           r_psc, w_psc_next;
  logic [1:0]           r_prev;
  logic [15:0]          r_io_oeb;
  logic                 w_match, w_wrap;

  logic [127:0] w_q;
  logic         w_run, w_mode, w_load_rise, w_clear_rise;

  assign w_q          = la_data_in & ~la_oenb;
  assign w_run        = w_q[96];
  assign w_mode       = w_q[99];
  assign w_load_rise  = w_q[97] & ~r_prev[0];
  assign w_clear_rise = w_q[98] & ~r_prev[1];

  // Compare bits only update where the SoC is actually driving them.
  assign w_cmp_next = (r_cmp & la_oenb[64 +: COUNT_W]) |
                      (la_data_in[64 +: COUNT_W] & ~la_oenb[64 +: COUNT_W]);

  always_comb begin
    w_state_next  = r_state;
    w_count_next  = r_count;
    w_done_next   = r_done;
    w_sticky_next = r_sticky;
    w_psc_next    = r_psc;
    w_match       = 1'b0;
    w_wrap        = 1'b0;
    if (w_clear_rise) begin
      w_count_next  = '0;
      w_done_next   = 1'b0;
      w_sticky_next = 1'b0;
      w_psc_next    = '0;
      w_state_next  = w_run ? StRun : StIdle;
    end else if (w_load_rise) begin
      w_count_next = w_q[32 +: COUNT_W];
      w_done_next  = 1'b0;
      w_psc_next   = '0;
      w_state_next = w_run ? StRun : StIdle;
    end else begin
      unique case (r_state)
        StIdle: begin
          w_psc_next = '0;
          if (w_run) w_state_next = StRun;
        end
        StRun: begin
          if (!w_run) begin
            w_state_next = StIdle;
            w_psc_next   = '0;
          end else if (r_psc == PsLast) begin
            w_psc_next = '0;
            if (r_count == r_cmp) begin
              w_match       = 1'b1;
              w_sticky_next = 1'b1;
              if (w_mode) begin
                w_state_next = StDone;
                w_done_next  = 1'b1;
              end else begin
                w_count_next = '0;
              end
            end else begin
              w_count_next = r_count + COUNT_W'(1);
              w_wrap       = &r_count;
            end
          end else begin
            w_psc_next = r_psc + 8'd1;
          end
        end
        StDone: begin
          w_psc_next = '0;
          if (!w_run) w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_state  <= StIdle;
      r_count  <= '0;
      r_cmp    <= '0;
      r_done   <= 1'b0;
      r_sticky <= 1'b0;
      r_psc    <= '0;
      r_prev   <= 2'b00;
      r_io_oeb <= 16'hFFFF;
    end else begin
      r_state  <= w_state_next;
      r_count  <= w_count_next;
      r_cmp    <= w_cmp_next;
      r_done   <= w_done_next;
      r_sticky <= w_sticky_next;
      r_psc    <= w_psc_next;
      r_prev   <= w_q[98:97];
      r_io_oeb <= 16'h0000;
    end
  end

  assign la_data_out = {{(128 - COUNT_W - 4){1'b0}}, r_state, r_sticky, r_done, r_count};
  assign io_out      = r_count[15:0];
  assign io_oeb      = r_io_oeb;

`ifdef LA_EVENT_IRQ_EN
  logic r_match_pulse, r_wrap_pulse;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      r_match_pulse <= 1'b0;
      r_wrap_pulse  <= 1'b0;
    end else begin
      r_match_pulse <= w_match;
      r_wrap_pulse  <= w_wrap;
    end
  end

  assign irq = {r_wrap_pulse, r_done, r_match_pulse};

  logic w_unused;
  assign w_unused = ^{w_q[127:100], w_q[95:64], w_q[31:0]};
`else
  assign irq = 3'b000;

  logic w_unused;
  assign w_unused = ^{w_q[127:100], w_q[95:64], w_q[31:0], w_match, w_wrap};
`endif

endmodule
